// File: rtl/cluster_link_scheduler.sv
// Compacts up to MXCLUSTERS clusters per bx into a FIFO and streams them one per clock4x.
// Optional CLUSTER_AGE_LIMIT_EN: entries carry a bx stamp and aged heads are discarded.
module cluster_link_scheduler #(
  parameter int MXCLSTBITS    = 14,
  parameter int MXCLUSTERS    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int CLOCKS_PER_BX = 4,
  parameter int MAX_AGE       = 3
) (
  input  logic                               clock4x,
  input  logic                               global_reset_n,
  input  logic                               enable,
  input  logic                               resync,
  input  logic                               bx_strobe,
  input  logic [MXCLUSTERS*MXCLSTBITS-1:0]   clusters_in,
  input  logic                               tx_ready,
  output logic [MXCLSTBITS-1:0]              tx_data,
  output logic                               tx_valid,
  output logic                               tx_frame_start,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic [15:0]                        overflow_cnt,
  output logic [15:0]                        stale_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(CLOCKS_PER_BX);
`ifdef CLUSTER_AGE_LIMIT_EN
  localparam int EW = MXCLSTBITS + 4;
`else
  localparam int EW = MXCLSTBITS;
`endif
  localparam logic [MXCLSTBITS-1:0] IDLE_WORD = MXCLSTBITS'(11'h7FF);

  if (FIFO_DEPTH < MXCLUSTERS || CLOCKS_PER_BX < 2 || MAX_AGE > 15)
  begin : g_bad_cfg
    $error("cluster_link_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  state_t state, state_n;

  logic                            run, go, off, clr, take;
  logic                            cap_vld;
  logic [MXCLUSTERS*MXCLSTBITS-1:0] cap_data;
  logic [EW-1:0]                   mem [FIFO_DEPTH];
  logic [AW-1:0]                   wptr, rptr;
  logic [SW-1:0]                   slot;
  logic [CW-1:0]                   free, nvalid, nwr;
  logic [MXCLUSTERS-1:0]           we;
  logic [AW-1:0]                   waddr [MXCLUSTERS];
  logic [EW-1:0]                   went [MXCLUSTERS];
  logic [EW-1:0]                   first, head;
  logic                            empty, avail, pop, stale;
  logic [MXCLSTBITS-1:0]           data_n;
  logic                            valid_n;
  logic [16:0]                     ovf_sum;
`ifdef CLUSTER_AGE_LIMIT_EN
  logic [3:0]                      bx_cnt, age;
`endif

  function automatic logic cl_ok(input logic [MXCLSTBITS-1:0] c);
    return c[10:0] != 11'h7FF;
  endfunction

  assign run  = (state == S_RUN);
  assign go   = run & enable;
  assign off  = (state == S_IDLE) | (run & ~enable);
  assign clr  = ~go | resync;
  assign take = go & ~resync & bx_strobe;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (enable) state_n = S_RUN;
      S_RUN: begin
        if (!enable)     state_n = S_IDLE;
        else if (resync) state_n = S_FLUSH;
      end
      S_FLUSH: state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < MXCLUSTERS; i++) begin
`ifdef CLUSTER_AGE_LIMIT_EN
      went[i] = {bx_cnt, cap_data[i*MXCLSTBITS +: MXCLSTBITS]};
`else
      went[i] = cap_data[i*MXCLSTBITS +: MXCLSTBITS];
`endif
    end
  end

  assign free = CW'(FIFO_DEPTH) - fifo_count;

  // Compaction: valid clusters take consecutive slots until space runs out
  always_comb begin
    nvalid = '0;
    nwr    = '0;
    we     = '0;
    first  = went[0];
    waddr  = '{default: '0};
    for (int i = 0; i < MXCLUSTERS; i++) begin
      waddr[i] = wptr + nwr[AW-1:0];
      if (go && cap_vld && cl_ok(cap_data[i*MXCLSTBITS +: MXCLSTBITS])) begin
        nvalid = nvalid + 1'b1;
        if (nwr < free) begin
          if (nwr == '0) first = went[i];
          we[i] = 1'b1;
          nwr   = nwr + 1'b1;
        end
      end
    end
  end

  // Empty FIFO bypasses the first new cluster straight to the output
  assign empty = (fifo_count == '0);
  assign head  = empty ? first : mem[rptr];
  assign avail = ~empty | (nwr != '0);

`ifdef CLUSTER_AGE_LIMIT_EN
  assign age   = bx_cnt - head[EW-1 -: 4];
  assign stale = age > 4'(MAX_AGE);
`else
  assign stale = 1'b0;
`endif

  always_comb begin
    pop     = 1'b0;
    data_n  = tx_data;
    valid_n = tx_valid;
    if (off) begin
      data_n  = IDLE_WORD;
      valid_n = 1'b0;
    end else if (tx_ready) begin
      data_n  = IDLE_WORD;
      valid_n = 1'b0;
      if (go && avail) begin
        pop = 1'b1;
        if (!stale) begin
          data_n  = head[MXCLSTBITS-1:0];
          valid_n = 1'b1;
        end
      end
    end
  end

  assign ovf_sum = {1'b0, overflow_cnt} + 17'(nvalid - nwr);
  assign tx_frame_start = run & (slot == '0);

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state        <= S_IDLE;
      cap_vld      <= 1'b0;
      cap_data     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      fifo_count   <= '0;
      slot         <= '0;
      tx_data      <= IDLE_WORD;
      tx_valid     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state    <= state_n;
      cap_vld  <= take;
      if (take) cap_data <= clusters_in;
      tx_data  <= data_n;
      tx_valid <= valid_n;
      if (clr) begin
        wptr       <= '0;
        rptr       <= '0;
        fifo_count <= '0;
      end else begin
        wptr       <= wptr + nwr[AW-1:0];
        rptr       <= rptr + AW'(pop);
        fifo_count <= fifo_count + nwr - CW'(pop);
      end
      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      if (clr || take)
        slot <= '0;
      else if (slot == SW'(CLOCKS_PER_BX - 1))
        slot <= '0;
      else
        slot <= slot + 1'b1;
    end
  end

  always_ff @(posedge clock4x) begin
    for (int i = 0; i < MXCLUSTERS; i++)
      if (we[i]) mem[waddr[i]] <= went[i];
  end

`ifdef CLUSTER_AGE_LIMIT_EN
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      bx_cnt    <= '0;
      stale_cnt <= '0;
    end else begin
      if (run && bx_strobe) bx_cnt <= bx_cnt + 1'b1;
      if (pop && stale && stale_cnt != 16'hFFFF)
        stale_cnt <= stale_cnt + 1'b1;
    end
  end
`else
  assign stale_cnt = '0;
`endif

endmodule

// File: tb/tb_cluster_link_scheduler.sv
// Bench for cluster_link_scheduler: directed scenarios plus random traffic
// checked against a queue-based frame model.
module tb_cluster_link_scheduler;
  localparam int CB     = 14;
  localparam int NCL    = 8;
  localparam int DEPTH  = 16;
  localparam int CPB    = 4;
  localparam int MAXAGE = 3;
  localparam logic [CB-1:0] IDLEW = 14'h07FF;

  logic                clock4x = 1'b0;
  logic                global_reset_n = 1'b1;
  logic                enable = 1'b0;
  logic                resync = 1'b0;
  logic                bx_strobe = 1'b0;
  logic [NCL*CB-1:0]   clusters_in = '0;
  logic                tx_ready = 1'b0;
  logic [CB-1:0]       tx_data;
  logic                tx_valid;
  logic                tx_frame_start;
  logic [4:0]          fifo_count;
  logic [15:0]         overflow_cnt;
  logic [15:0]         stale_cnt;

  cluster_link_scheduler #(
    .MXCLSTBITS(CB), .MXCLUSTERS(NCL), .FIFO_DEPTH(DEPTH),
    .CLOCKS_PER_BX(CPB), .MAX_AGE(MAXAGE)
  ) dut (
    .clock4x(clock4x), .global_reset_n(global_reset_n),
    .enable(enable), .resync(resync), .bx_strobe(bx_strobe),
    .clusters_in(clusters_in), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_frame_start(tx_frame_start), .fifo_count(fifo_count),
    .overflow_cnt(overflow_cnt), .stale_cnt(stale_cnt)
  );

  always #5 clock4x = ~clock4x;

  int n_vec = 0;
  int n_err = 0;
  int emits = 0;
  int fs_cnt = 0;
`ifdef CLUSTER_AGE_LIMIT_EN
  bit seen = 0;
`endif

  // model: 0 idle, 1 run, 2 flush
  int mst, mslot, movf, mstale, mbx;
  logic [CB-1:0] mdata;
  bit mvalid;
  int mq[$];
  int mcap[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ok(input logic [CB-1:0] c);
    return c[10:0] != 11'h7FF;
  endfunction

  function automatic logic [NCL*CB-1:0] idles();
    logic [NCL*CB-1:0] c;
    for (int i = 0; i < NCL; i++) c[i*CB +: CB] = IDLEW;
    return c;
  endfunction

  function automatic logic [NCL*CB-1:0] mk(input int nv, input int pct);
    logic [NCL*CB-1:0] c;
    for (int i = 0; i < NCL; i++) begin
      if (i < nv || $urandom_range(0, 99) < pct)
        c[i*CB +: CB] = {3'($urandom), 11'($urandom_range(0, 2046))};
      else
        c[i*CB +: CB] = {3'($urandom), 11'h7FF};
    end
    return c;
  endfunction

  task automatic model_reset();
    mst = 0; mslot = 0; movf = 0; mstale = 0; mbx = 0;
    mdata = IDLEW; mvalid = 0;
    mq.delete(); mcap.delete();
  endtask

  task automatic model_step();
    int cnt, wr, e, pre;
`ifdef CLUSTER_AGE_LIMIT_EN
    int age;
`endif
    pre = mst; cnt = mq.size(); wr = 0;
    if (mst == 0) begin
      mq.delete(); mcap.delete();
      mdata = IDLEW; mvalid = 0; mslot = 0;
      if (enable) mst = 1;
    end else if (mst == 2) begin
      mq.delete(); mcap.delete(); mslot = 0; mst = 1;
      if (tx_ready) begin mdata = IDLEW; mvalid = 0; end
    end else if (!enable) begin
      mq.delete(); mcap.delete();
      mdata = IDLEW; mvalid = 0; mslot = 0; mst = 0;
    end else begin
      foreach (mcap[i]) begin
        if (wr < DEPTH - cnt) begin
          mq.push_back((mbx << 16) | mcap[i]);
          wr++;
        end else if (movf < 65535) movf++;
      end
      if (tx_ready) begin
        mdata = IDLEW; mvalid = 0;
        if (mq.size() != 0) begin
          e = mq.pop_front();
`ifdef CLUSTER_AGE_LIMIT_EN
          age = (mbx - (e >> 16)) & 15;
          if (age > MAXAGE) begin
            if (mstale < 65535) mstale++;
          end else
`endif
          begin
            mdata = e[13:0]; mvalid = 1;
          end
        end
      end
      mcap.delete();
      if (resync) begin
        mq.delete(); mslot = 0; mst = 2;
      end else begin
        if (bx_strobe)
          for (int i = 0; i < NCL; i++)
            if (ok(clusters_in[i*CB +: CB]))
              mcap.push_back(int'(clusters_in[i*CB +: CB]));
        mslot = bx_strobe ? 0 : (mslot + 1) % CPB;
      end
    end
    if (pre == 1 && bx_strobe) mbx = (mbx + 1) % 16;
  endtask

  task automatic cyc(input bit en, input bit rs, input bit bx,
                     input bit rdy, input logic [NCL*CB-1:0] cl);
    enable = en; resync = rs; bx_strobe = bx;
    tx_ready = rdy; clusters_in = cl;
    @(posedge clock4x);
    model_step();
    #1;
    check("tx_data", 32'(tx_data), 32'(mdata));
    check("tx_valid", 32'(tx_valid), 32'(mvalid));
    check("frame_start", 32'(tx_frame_start),
          32'(mst == 1 && mslot == 0));
    check("fifo_count", 32'(fifo_count), mq.size());
    check("overflow_cnt", 32'(overflow_cnt), movf);
    check("stale_cnt", 32'(stale_cnt), mstale);
    if (rdy && tx_valid) emits++;
    if (tx_frame_start) fs_cnt++;
`ifdef CLUSTER_AGE_LIMIT_EN
    if (tx_valid && tx_data == 14'h0100) seen = 1;
`endif
  endtask

  task automatic do_reset();
    #2 global_reset_n = 1'b0;
    enable = 0; resync = 0; bx_strobe = 0; tx_ready = 0;
    clusters_in = idles();
    model_reset();
    #1;
    check("rst_data", 32'(tx_data), 32'h7FF);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_frame", 32'(tx_frame_start), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow_cnt), 0);
    check("rst_stale", 32'(stale_cnt), 0);
    @(negedge clock4x);
    @(negedge clock4x);
    global_reset_n = 1'b1;
  endtask

  initial begin
    logic [NCL*CB-1:0] c;

    do_reset();
    repeat (6) cyc(0, 0, 1, 1, mk(0, 60));
    check("idle_count", 32'(fifo_count), 0);

    cyc(1, 0, 0, 1, idles());
    c = idles();
    c[CB-1:0] = 14'h1234;
    cyc(1, 0, 1, 1, c);
    cyc(1, 0, 0, 1, idles());
    check("single_data", 32'(tx_data), 32'h1234);
    check("single_valid", 32'(tx_valid), 1);
    cyc(1, 0, 0, 1, idles());
    check("single_count", 32'(fifo_count), 0);

    do_reset();
    cyc(1, 0, 0, 0, idles());
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 0, mk(8, 0));
      repeat (3) cyc(1, 0, 0, 0, idles());
    end
    check("ovf_count", 32'(fifo_count), 16);
    check("ovf_dropped", 32'(overflow_cnt), 8);
    repeat (8) cyc(1, 0, 0, 1, idles());
    do_reset();

    cyc(1, 0, 0, 0, idles());
    emits = 0;
    for (int k = 0; k < 12; k++)
      cyc(1, 0, k == 0, k % 2 == 0, k == 0 ? mk(4, 0) : idles());
    check("bp_emits", emits, 4);
    fs_cnt = 0;
    repeat (8) cyc(1, 0, 0, 1, idles());
    check("frame_period", fs_cnt, 8 / CPB);

    cyc(1, 0, 1, 0, mk(5, 0));
    repeat (3) cyc(1, 0, 0, 0, idles());
    check("rs_pre_count", 32'(fifo_count), 5);
    cyc(1, 1, 0, 0, idles());
    check("rs_count", 32'(fifo_count), 0);
    check("rs_ovf", 32'(overflow_cnt), 0);
    cyc(1, 0, 0, 0, idles());
    c = idles();
    c[CB-1:0] = 14'h0ABC;
    cyc(1, 0, 1, 1, c);
    cyc(1, 0, 0, 1, idles());
    check("rs_data", 32'(tx_data), 32'h0ABC);

    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, CPB - 1) == 0, $urandom_range(0, 9) < 7,
          mk(0, 60));

`ifdef CLUSTER_AGE_LIMIT_EN
    do_reset();
    cyc(1, 0, 0, 0, idles());
    c = idles();
    c[CB-1:0] = 14'h0100;
    cyc(1, 0, 1, 0, c);
    repeat (3) cyc(1, 0, 0, 0, idles());
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1, 0, idles());
      repeat (3) cyc(1, 0, 0, 0, idles());
    end
    seen = 0;
    repeat (4) cyc(1, 0, 0, 1, idles());
    check("age_stale", 32'(stale_cnt), 1);
    check("age_seen", 32'(seen), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
